// File: rtl/lct_l1a_matcher.sv
// Matches each L1A against per-channel LCT history in a programmable look-back window; tracks ALCT/TMB DAV handshakes.
// Latency: l1a_out/l1a_match/nomatch/l1a_cnt one cycle after l1a; error pulses one cycle after the offending strobe.
// Backpressure: none, the input stream is consumed every cycle and nothing stalls.
module lct_l1a_matcher #(
    parameter int NCH   = 8,
    parameter int DEPTH = 32,
    parameter int CNT_W = 24,
    parameter int OUT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             l1a,
    input  logic [NCH-1:0]   lct,
    input  logic             alct_dav,
    input  logic             tmb_dav,
    input  logic [4:0]       lct_l1a_dly,
    input  logic [2:0]       match_win,
    input  logic [NCH-1:0]   kill,
    output logic             l1a_out,
    output logic [NCH-1:0]   l1a_match,
    output logic [CNT_W-1:0] l1a_cnt,
    output logic             nomatch,
    output logic             alct_err,
    output logic             tmb_err,
    output logic [OUT_W-1:0] alct_pend,
    output logic [OUT_W-1:0] tmb_pend
);

    // hist_q[i][k-1] holds lct[i] as sampled k cycles ago
    logic [NCH-1:0][DEPTH-1:0] hist_q, hist_d;
    logic [DEPTH-1:0]          win_mask;
    logic [6:0]                win_lo, win_hi;
    logic [NCH-1:0]            take;

    logic             l1a_out_q,   l1a_out_d;
    logic [NCH-1:0]   l1a_match_q, l1a_match_d;
    logic             nomatch_q,   nomatch_d;
    logic [CNT_W-1:0] l1a_cnt_q,   l1a_cnt_d;
    logic             alct_err_q,  alct_err_d;
    logic             tmb_err_q,   tmb_err_d;
    logic [OUT_W-1:0] alct_pend_q, alct_pend_d;
    logic [OUT_W-1:0] tmb_pend_q,  tmb_pend_d;

    // Returns {err, next_pend}; simultaneous inc and dec cancel out
    function automatic logic [OUT_W:0] pend_step(input logic [OUT_W-1:0] pend,
                                                 input logic inc, input logic dec);
        logic [OUT_W-1:0] nxt;
        logic             err;
        nxt = pend;
        err = 1'b0;
        if (inc && !dec) begin
            if (&pend) err = 1'b1;
            else       nxt = pend + OUT_W'(1);
        end else if (dec && !inc) begin
            if (pend == '0) err = 1'b1;
            else            nxt = pend - OUT_W'(1);
        end
        return {err, nxt};
    endfunction

    // Window k = lo..hi; the upper clip to DEPTH falls out of k never exceeding DEPTH
    always_comb begin
        win_lo = (lct_l1a_dly == 5'd0) ? 7'd1 : {2'b00, lct_l1a_dly};
        win_hi = win_lo + {4'b0000, match_win};
        win_mask = '0;
        for (int k = 0; k < DEPTH; k++) begin
            win_mask[k] = (7'(k + 1) >= win_lo) && (7'(k + 1) <= win_hi);
        end
    end

    always_comb begin
        hist_d      = hist_q;
        l1a_match_d = '0;
        take        = '0;
        for (int i = 0; i < NCH; i++) begin
            take[i]        = l1a && !kill[i];
            l1a_match_d[i] = take[i] && (|(hist_q[i] & win_mask));
            // Consumed bits are cleared as they shift so an LCT serves one L1A only
            hist_d[i] = {hist_q[i][DEPTH-2:0] & ~(win_mask[DEPTH-2:0] & {(DEPTH-1){take[i]}}),
                         lct[i]};
        end
    end

    always_comb begin
        l1a_out_d = l1a;
        nomatch_d = l1a && (l1a_match_d == '0);
        l1a_cnt_d = l1a ? (l1a_cnt_q + CNT_W'(1)) : l1a_cnt_q;
        {alct_err_d, alct_pend_d} = pend_step(alct_pend_q, l1a_out_q, alct_dav);
        {tmb_err_d,  tmb_pend_d}  = pend_step(tmb_pend_q,  l1a_out_q, tmb_dav);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist_q      <= '0;
            l1a_out_q   <= 1'b0;
            l1a_match_q <= '0;
            nomatch_q   <= 1'b0;
            l1a_cnt_q   <= '0;
            alct_err_q  <= 1'b0;
            tmb_err_q   <= 1'b0;
            alct_pend_q <= '0;
            tmb_pend_q  <= '0;
        end else begin
            hist_q      <= hist_d;
            l1a_out_q   <= l1a_out_d;
            l1a_match_q <= l1a_match_d;
            nomatch_q   <= nomatch_d;
            l1a_cnt_q   <= l1a_cnt_d;
            alct_err_q  <= alct_err_d;
            tmb_err_q   <= tmb_err_d;
            alct_pend_q <= alct_pend_d;
            tmb_pend_q  <= tmb_pend_d;
        end
    end

    assign l1a_out   = l1a_out_q;
    assign l1a_match = l1a_match_q;
    assign nomatch   = nomatch_q;
    assign l1a_cnt   = l1a_cnt_q;
    assign alct_err  = alct_err_q;
    assign tmb_err   = tmb_err_q;
    assign alct_pend = alct_pend_q;
    assign tmb_pend  = tmb_pend_q;

endmodule

// File: doc/lct_l1a_matcher.md
Name: lct_l1a_matcher

Overview:
- Consumes the per-cycle stimulus stream (l1a, alct_dav, tmb_dav, lct[7:0]) produced by the event file handler in the ODMB simulation environment.
- Keeps a per-channel LCT history and, on each L1A, matches the L1A against LCTs that fell in a programmable look-back window.
- Emits a registered L1A, a per-channel L1A_MATCH vector and a 24-bit L1A counter.
- Tracks ALCT/TMB data-available handshakes against issued L1As and flags protocol errors.

Parameters:
- NCH, 8, number of LCT channels (lct bit i = channel i).
- DEPTH, 32, LCT history depth in cycles (max look-back).
- CNT_W, 24, L1A counter width.
- OUT_W, 4, outstanding-DAV counter width.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- l1a  in  1  L1A strobe, one cycle per trigger.
- lct  in  NCH  per-channel LCT strobes.
- alct_dav  in  1  ALCT data-available strobe.
- tmb_dav  in  1  TMB data-available strobe.
- lct_l1a_dly  in  5  LCT-to-L1A latency in cycles, valid 1..DEPTH-1.
- match_win  in  3  extra window width in cycles; 0 means single cycle.
- kill  in  NCH  channel mask; 1 forces no match on that channel.
- l1a_out  out  1  registered L1A.
- l1a_match  out  NCH  per-channel match, aligned with l1a_out.
- l1a_cnt  out  CNT_W  L1A count including the current L1A, valid with l1a_out.
- nomatch  out  1  pulse with l1a_out when l1a_match is all zero.
- alct_err  out  1  ALCT DAV protocol error pulse.
- tmb_err  out  1  TMB DAV protocol error pulse.
- alct_pend  out  OUT_W  outstanding L1As awaiting alct_dav.
- tmb_pend  out  OUT_W  outstanding L1As awaiting tmb_dav.

Behaviour:
- Reset (asynchronous) clears:
  - all outputs to 0;
  - history to 0;
  - the L1A counter and both pending counters to 0.
- Reset asserted mid-operation discards any in-flight match. The first post-reset L1A reports l1a_cnt=1.
- History:
  - hist[i][k] = lct[i] sampled k cycles before the current cycle, k=1..DEPTH.
  - Shifts every cycle. The oldest entry drops off.
- Window for an L1A at cycle t covers k = D..D+W, where D=lct_l1a_dly and W=match_win.
  - Upper bound is clipped to DEPTH.
  - D=0 is treated as 1.
  - The current-cycle lct is never in the window.
- Match:
  - m[i] = OR of hist[i][k] over the window AND NOT kill[i].
  - Registered: l1a_out, l1a_match and nomatch appear at t+1 (latency 1).
  - l1a_match and nomatch are 0 when l1a_out is 0.
- LCT consumption:
  - On an L1A, every history bit that contributed to a match is cleared in the same shift, so an LCT matches at most one L1A.
  - Killed channels are not cleared.
  - Two L1As inside one window: the first takes the LCT, the second reports no match on that channel.
- L1A counter:
  - Increments on each l1a.
  - l1a_cnt updates with l1a_out and holds between L1As.
  - Wraps from 2^CNT_W-1 to 0 with no flag.
- Pending counters (ALCT and TMB independently):
  - Increment on l1a_out, decrement on dav.
  - Both in the same cycle: value unchanged, no error.
  - dav while pending=0 and no simultaneous l1a_out: err pulses 1 cycle, pending stays 0.
  - l1a_out while pending=2^OUT_W-1 and no simultaneous dav: err pulses, pending saturates.
- Config inputs are sampled every cycle. Changing them between L1As is legal; the effect applies to the next L1A.
- lct asserted on consecutive cycles fills consecutive history slots. Each slot is matched and consumed individually.

Test Plan:
- D=5, W=0: lct[3] pulse at cycle 10, l1a at 15 -> l1a_out at 16, l1a_match=8'h08, l1a_cnt=1, nomatch=0.
- D=5, W=0: lct[3] at 10, l1a at 16 -> l1a_match=0, nomatch=1. With W=2 and l1a at 17 -> match=8'h08.
- D=4, W=3: lct[1] at 20, l1a at 24 and 26 -> first l1a_match=8'h02, second 8'h00 (consumed). With kill[1]=1 both give 0 and the bit is not consumed.
- 3 L1As then 3 alct_dav -> alct_pend goes 1,2,3,2,1,0 with no alct_err. An extra alct_dav -> alct_err pulses once, pend stays 0. l1a_out and alct_dav in the same cycle -> pend unchanged.
- 16 L1As with no tmb_dav -> tmb_pend saturates at 15, tmb_err pulses on the 16th.
- Counter preset via 2^24-1 L1As (or forced) -> next l1a gives l1a_cnt=0. Assert rst mid-window with an LCT in history -> outputs 0 immediately, next L1A reports cnt=1, match=0.
